// File: rtl/ex_mem_stage_reg.sv
// rtl/ex_mem_stage_reg.sv - EX/MEM pipeline register with 2-entry skid buffer, flush and stall counter
// Head register drives MEM; skid register absorbs one extra entry so in_ready can be registered.
module ex_mem_stage_reg #(
  parameter int DATA_W = 64,
  parameter int LANES  = 3,
  parameter int CTRL_W = 12,
  parameter int DEST_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0]       in_ctrl,
  input  logic [DEST_W-1:0]       in_dest,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0]       out_ctrl,
  output logic [DEST_W-1:0]       out_dest,
  output logic [CNT_W-1:0]        stall_cnt
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

  state_t                  state, state_nxt;
  logic [LANES*DATA_W-1:0] head_data, skid_data;
  logic [CTRL_W-1:0]       head_ctrl, skid_ctrl;
  logic [DEST_W-1:0]       head_dest, skid_dest;
  logic                    in_fire, out_fire;
  logic                    load_head_in, load_skid, load_head_skid;

  // Both handshake outputs come straight from the state register.
  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= EMPTY;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY:   if (in_fire) state_nxt = ONE;
        ONE:     if (in_fire && !out_fire) state_nxt = TWO;
                 else if (!in_fire && out_fire) state_nxt = EMPTY;
        TWO:     if (out_fire) state_nxt = ONE;
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_comb begin
    load_head_in   = 1'b0;
    load_skid      = 1'b0;
    load_head_skid = 1'b0;
    if (!flush) begin
      case (state)
        EMPTY:   load_head_in = in_fire;
        ONE: begin
          load_head_in = in_fire & out_fire;
          load_skid    = in_fire & ~out_fire;
        end
        TWO:     load_head_skid = out_fire;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_data <= '0;
      head_ctrl <= '0;
      head_dest <= '0;
    end else if (load_head_in) begin
      head_data <= in_data;
      head_ctrl <= in_ctrl;
      head_dest <= in_dest;
    end else if (load_head_skid) begin
      head_data <= skid_data;
      head_ctrl <= skid_ctrl;
      head_dest <= skid_dest;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      skid_data <= '0;
      skid_ctrl <= '0;
      skid_dest <= '0;
    end else if (load_skid) begin
      skid_data <= in_data;
      skid_ctrl <= in_ctrl;
      skid_dest <= in_dest;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                   stall_cnt <= '0;
    else if (out_valid && !out_ready && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
  end

  // Bubbles must never carry REGWRITE/MEMWRITE into MEM.
  assign out_ctrl = out_valid ? head_ctrl : '0;
  assign out_data = head_data;
  assign out_dest = head_dest;

endmodule

// File: tb/tb_ex_mem_stage_reg.sv
// tb/tb_ex_mem_stage_reg.sv - self-checking bench for ex_mem_stage_reg against a 2-deep queue model
module tb_ex_mem_stage_reg;

  typedef struct {
    logic [191:0] d;
    logic [11:0]  c;
    logic [4:0]   dst;
  } ent_t;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         flush;
  logic         in_valid;
  logic [191:0] in_data;
  logic [11:0]  in_ctrl;
  logic [4:0]   in_dest;
  logic         out_ready;
  logic         in_ready, out_valid, in_ready3, out_valid3;
  logic [191:0] out_data, out_data3;
  logic [11:0]  out_ctrl, out_ctrl3;
  logic [4:0]   out_dest, out_dest3;
  logic [15:0]  stall_cnt;
  logic [2:0]   stall_cnt3;

  int   n_vec = 0;
  int   n_err = 0;
  ent_t q[$];
  ent_t shown;
  int   stall, stall3;

  always #5 clk = ~clk;

  ex_mem_stage_reg dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .in_dest(in_dest), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl), .out_dest(out_dest),
    .stall_cnt(stall_cnt)
  );

  ex_mem_stage_reg #(.CNT_W(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready3),
    .in_data(in_data), .in_ctrl(in_ctrl), .in_dest(in_dest), .out_valid(out_valid3),
    .out_ready(out_ready), .out_data(out_data3), .out_ctrl(out_ctrl3), .out_dest(out_dest3),
    .stall_cnt(stall_cnt3)
  );

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    shown.d = '0; shown.c = '0; shown.dst = '0;
    stall = 0; stall3 = 0;
  endtask

  task automatic check_model();
    logic v;
    v = (q.size() != 0);
    check("out_valid", out_valid, v);
    check("in_ready", in_ready, q.size() < 2);
    check("out_data", out_data, shown.d);
    check("out_ctrl", out_ctrl, v ? shown.c : 12'h0);
    check("out_dest", out_dest, shown.dst);
    check("stall_cnt", stall_cnt, stall);
    check("stall_cnt3", stall_cnt3, stall3);
    check("out_valid3", out_valid3, v);
    check("out_ctrl3", out_ctrl3, v ? shown.c : 12'h0);
  endtask

  // Check outputs for this cycle, clock once, then advance the model.
  task automatic cycle();
    logic in_acc, out_acc;
    ent_t e;
    #1;
    check_model();
    in_acc  = in_valid && (q.size() < 2);
    out_acc = (q.size() != 0) && out_ready;
    e.d = in_data; e.c = in_ctrl; e.dst = in_dest;
    if (q.size() != 0 && !out_ready) begin
      if (stall < 65535) stall++;
      if (stall3 < 7) stall3++;
    end
    @(posedge clk);
    #1;
    if (flush) q.delete();
    else begin
      if (out_acc) void'(q.pop_front());
      if (in_acc) q.push_back(e);
    end
    if (q.size() != 0) shown = q[0];
  endtask

  task automatic drive(input logic v, input logic [191:0] d, input logic [11:0] c,
                       input logic [4:0] dst, input logic ordy, input logic fl);
    in_valid = v; in_data = d; in_ctrl = c; in_dest = dst; out_ready = ordy; flush = fl;
  endtask

  function automatic logic [191:0] lane1(input logic [63:0] x);
    logic [191:0] r;
    r = '0;
    r[127:64] = x;
    return r;
  endfunction

  function automatic logic [191:0] rnd192();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [191:0] od;
    model_reset();
    reset_n = 1'b0;
    drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
    #12;
    check_model();
    @(posedge clk);
    #1 reset_n = 1'b1;

    // Test 1: single entry, one-cycle latency.
    drive(1'b1, lane1(64'h5), 12'h0C1, 5'd7, 1'b1, 1'b0);
    cycle();
    od = out_data;
    check("t1_valid", out_valid, 1'b1);
    check("t1_lane1", od[127:64], 64'h5);
    check("t1_dest", out_dest, 5'd7);
    check("t1_ctrl", out_ctrl, 12'h0C1);
    check("t1_ready", in_ready, 1'b1);

    // Test 2: back-to-back stream with no backpressure.
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, lane1(64'(k)), 12'(k), 5'(k), 1'b1, 1'b0);
      cycle();
      od = out_data;
      check("t2_lane1", od[127:64], 64'(k));
    end
    drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
    cycle();
    check("t2_stall", stall_cnt, 16'd0);

    // Test 4: fill to TWO, stall counts 5, then CNT_W=3 saturates after 10.
    drive(1'b1, lane1(64'hA1), 12'hFFF, 5'd1, 1'b0, 1'b0);
    cycle();
    drive(1'b1, lane1(64'hA2), 12'hF0F, 5'd2, 1'b0, 1'b0);
    cycle();
    check("t4_ready_two", in_ready, 1'b0);
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) cycle();
    check("t4_stall5", stall_cnt, 16'd5);
    for (int k = 0; k < 5; k++) cycle();
    check("t4_stall10", stall_cnt, 16'd10);
    check("t4_sat3", stall_cnt3, 3'd7);

    // Test 5: flush in TWO with a concurrent offer.
    drive(1'b1, lane1(64'hBAD), 12'hFFF, 5'd31, 1'b0, 1'b1);
    cycle();
    check("t5_valid", out_valid, 1'b0);
    check("t5_ctrl", out_ctrl, 12'h0);
    check("t5_ready", in_ready, 1'b1);
    drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
    cycle();

    // Test 3: three offers under backpressure, then drain.
    for (int k = 1; k <= 3; k++) begin
      drive(1'b1, lane1(64'(16 + k)), 12'h0A0, 5'(k), 1'b0, 1'b0);
      cycle();
      if (k == 2) check("t3_ready_drop", in_ready, 1'b0);
    end
    drive(1'b1, lane1(64'd19), 12'h0A0, 5'd3, 1'b1, 1'b0);
    cycle();
    cycle();
    drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) cycle();

    // Randomized traffic with occasional flushes.
    for (int k = 0; k < 400; k++) begin
      drive(1'($urandom_range(0, 3) != 0), rnd192(), 12'($urandom), 5'($urandom),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
      cycle();
    end

    // Test 6: asynchronous reset mid-stream.
    drive(1'b1, rnd192(), 12'h123, 5'd9, 1'b0, 1'b0);
    cycle();
    cycle();
    check("t6_pre_valid", out_valid, 1'b1);
    #3 reset_n = 1'b0;
    #1;
    model_reset();
    check("t6_valid", out_valid, 1'b0);
    check("t6_data", out_data, 192'h0);
    check("t6_ctrl", out_ctrl, 12'h0);
    check("t6_dest", out_dest, 5'h0);
    check("t6_ready", in_ready, 1'b1);
    check("t6_stall", stall_cnt, 16'h0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    drive(1'b1, rnd192(), 12'h456, 5'd4, 1'b1, 1'b0);
    cycle();
    drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
    cycle();
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
